// File: rtl/spi_reg_write_arbiter_if.sv
// Handshake and register-bank bus between the SPI capture stage / local requester
// and spi_reg_write_arbiter. The master drives requests; the slave (arbiter) owns the bank.
interface spi_reg_write_arbiter_if #(
  parameter int NUM_REGS = 5
);
  logic                  spi_valid;
  logic [15:0]           spi_frame;
  logic                  spi_ready;
  logic                  loc_valid;
  logic [6:0]            loc_addr;
  logic [7:0]            loc_data;
  logic                  loc_ready;
  logic                  reg_we;
  logic [6:0]            reg_addr;
  logic [7:0]            reg_wdata;
  logic                  reject;
  logic [NUM_REGS*8-1:0] regs_flat;

  modport master (
    output spi_valid, spi_frame, loc_valid, loc_addr, loc_data,
    input  spi_ready, loc_ready, reg_we, reg_addr, reg_wdata, reject, regs_flat
  );

  modport slave (
    input  spi_valid, spi_frame, loc_valid, loc_addr, loc_data,
    output spi_ready, loc_ready, reg_we, reg_addr, reg_wdata, reject, regs_flat
  );
endinterface

// File: rtl/spi_reg_write_arbiter.sv
// Round-robin write arbiter for the PWM/OE register bank: IDLE -> CHECK -> COMMIT per grant.
// Optional saturating reject counter on port err_cnt when REG_WRITE_ERR_CNT_EN is defined.
module spi_reg_write_arbiter #(
  parameter int NUM_REGS = 5,
  parameter int MAX_ADDR = 4
) (
  input  logic clk,
  input  logic rst_n,
  spi_reg_write_arbiter_if.slave bus
`ifdef REG_WRITE_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;
  localparam logic SRC_SPI = 1'b1;
  localparam logic SRC_LOC = 1'b0;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       hold_rw_q, hold_rw_d;
  logic [6:0] hold_addr_q, hold_addr_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       reg_we_q, reg_we_d;
  logic       reject_q, reject_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic [7:0] bank_q [NUM_REGS];
  logic [7:0] bank_d [NUM_REGS];

  logic spi_win;
  logic loc_win;
  logic write_ok;

  // On a tie the requester that did not win last time gets the grant.
  assign spi_win  = bus.spi_valid && (!bus.loc_valid || last_grant_q == SRC_LOC);
  assign loc_win  = bus.loc_valid && !spi_win;
  assign write_ok = hold_rw_q && (hold_addr_q <= 7'(MAX_ADDR));

  assign bus.spi_ready = (state_q == IDLE) && spi_win;
  assign bus.loc_ready = (state_q == IDLE) && loc_win;
  assign bus.reg_we    = reg_we_q;
  assign bus.reject    = reject_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_rw_d    = hold_rw_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    reg_we_d     = 1'b0;
    reject_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.spi_ready) begin
          hold_rw_d    = bus.spi_frame[15];
          hold_addr_d  = bus.spi_frame[14:8];
          hold_data_d  = bus.spi_frame[7:0];
          last_grant_d = SRC_SPI;
          state_d      = CHECK;
        end else if (bus.loc_ready) begin
          // Local requests carry no rw bit; they are always writes.
          hold_rw_d    = 1'b1;
          hold_addr_d  = bus.loc_addr;
          hold_data_d  = bus.loc_data;
          last_grant_d = SRC_LOC;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        reg_we_d = write_ok;
        reject_d = !write_ok;
        if (write_ok) begin
          reg_addr_d  = hold_addr_q;
          reg_wdata_d = hold_data_q;
        end
        state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bank
      assign bank_d[gi] = (reg_we_q && reg_addr_q == 7'(gi)) ? reg_wdata_q : bank_q[gi];
      assign bus.regs_flat[gi*8 +: 8] = bank_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_LOC;
      hold_rw_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      reg_we_q     <= 1'b0;
      reject_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      for (int k = 0; k < NUM_REGS; k++) bank_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_rw_q    <= hold_rw_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      reg_we_q     <= reg_we_d;
      reject_q     <= reject_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      for (int k = 0; k < NUM_REGS; k++) bank_q[k] <= bank_d[k];
    end
  end

`ifdef REG_WRITE_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  assign err_cnt_d = (reject_q && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  assign err_cnt   = err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end
`endif

endmodule

// File: tb/tb_spi_reg_write_arbiter.sv
// Randomised self-checking bench for spi_reg_write_arbiter against a transaction-level model.
// Build with +define+REG_WRITE_ERR_CNT_EN to also exercise the reject counter.
module tb_spi_reg_write_arbiter;

  localparam int NREG = 5;
  localparam int MAXA = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_reg_write_arbiter_if #(.NUM_REGS(NREG)) bus ();

`ifdef REG_WRITE_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  spi_reg_write_arbiter #(.NUM_REGS(NREG), .MAX_ADDR(MAXA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef REG_WRITE_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bank contents, fairness memory, last committed write, reject count.
  logic [7:0] m_regs [NREG];
  bit         m_last_spi;
  logic [6:0] m_addr;
  logic [7:0] m_wdata;
  int         m_err;

  function automatic logic [NREG*8-1:0] m_flat();
    logic [NREG*8-1:0] f;
    for (int k = 0; k < NREG; k++) f[k*8 +: 8] = m_regs[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
    m_last_spi = 1'b0;
    m_addr     = 7'h00;
    m_wdata    = 8'h00;
    m_err      = 0;
  endtask

  task automatic idle_inputs();
    bus.spi_valid = 1'b0;
    bus.spi_frame = 16'h0000;
    bus.loc_valid = 1'b0;
    bus.loc_addr  = 7'h00;
    bus.loc_data  = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // One request attempt, entered on a negedge with the arbiter idle; returns on the
  // negedge of cycle N+3 (or the next negedge if nothing was granted).
  task automatic transact(input bit sv, input logic [15:0] fr, input bit lv,
                          input logic [6:0] la, input logic [7:0] ld, input string tag);
    bit exp_spi, exp_loc, rw, ok;
    logic [6:0] a;
    logic [7:0] d;
    bus.spi_valid = sv;
    bus.spi_frame = fr;
    bus.loc_valid = lv;
    bus.loc_addr  = la;
    bus.loc_data  = ld;
    #1;
    exp_spi = sv && (!lv || !m_last_spi);
    exp_loc = lv && !exp_spi;
    n_vec++;
    if ({bus.spi_ready, bus.loc_ready} !== {exp_spi, exp_loc}) begin
      n_err++;
      $display("FAIL %s grant: spi_ready/loc_ready=%b%b expected %b%b", tag,
               bus.spi_ready, bus.loc_ready, exp_spi, exp_loc);
    end
    if (!exp_spi && !exp_loc) begin
      idle_inputs();
      @(negedge clk);
    end else begin
      if (exp_spi) begin
        rw = fr[15]; a = fr[14:8]; d = fr[7:0];
      end else begin
        rw = 1'b1; a = la; d = ld;
      end
      ok = rw && (a <= MAXA);
      m_last_spi = exp_spi;
      @(negedge clk);
      n_vec++;
      if ({bus.spi_ready, bus.loc_ready} !== 2'b00) begin
        n_err++;
        $display("FAIL %s busy_ready: spi_ready/loc_ready=%b%b expected 00", tag,
                 bus.spi_ready, bus.loc_ready);
      end
      idle_inputs();
      @(negedge clk);
      if (ok) begin
        m_addr  = a;
        m_wdata = d;
      end
      n_vec++;
      if ({bus.reg_we, bus.reject, bus.reg_addr, bus.reg_wdata} !== {ok, !ok, m_addr, m_wdata}) begin
        n_err++;
        $display("FAIL %s strobe: we=%b rej=%b addr=%h data=%h expected we=%b rej=%b addr=%h data=%h",
                 tag, bus.reg_we, bus.reject, bus.reg_addr, bus.reg_wdata, ok, !ok, m_addr, m_wdata);
      end
      if (ok) m_regs[a] = d;
      else if (m_err < 255) m_err++;
      @(negedge clk);
      n_vec++;
      if ({bus.regs_flat, bus.reg_we, bus.reject} !== {m_flat(), 2'b00}) begin
        n_err++;
        $display("FAIL %s bank: regs_flat=%h we=%b rej=%b expected regs_flat=%h we=0 rej=0",
                 tag, bus.regs_flat, bus.reg_we, bus.reject, m_flat());
      end
`ifdef REG_WRITE_ERR_CNT_EN
      n_vec++;
      if (err_cnt !== 8'(m_err)) begin
        n_err++;
        $display("FAIL %s err_cnt: got %0d expected %0d", tag, err_cnt, m_err);
      end
`endif
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.regs_flat, bus.reg_we, bus.reject, bus.spi_ready, bus.loc_ready, bus.reg_addr, bus.reg_wdata}
        !== '0) begin
      n_err++;
      $display("FAIL reset_hold: regs=%h we=%b rej=%b rdy=%b%b addr=%h data=%h expected all zero",
               bus.regs_flat, bus.reg_we, bus.reject, bus.spi_ready, bus.loc_ready,
               bus.reg_addr, bus.reg_wdata);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_vec++;
    if ({bus.regs_flat, bus.reg_we, bus.reject, bus.spi_ready, bus.loc_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_release: regs=%h we=%b rej=%b rdy=%b%b expected all zero",
               bus.regs_flat, bus.reg_we, bus.reject, bus.spi_ready, bus.loc_ready);
    end
`ifdef REG_WRITE_ERR_CNT_EN
    n_vec++;
    if (err_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL reset_err_cnt: got %h expected 00", err_cnt);
    end
`endif
  endtask

  task automatic test_spi_write();
    transact(1'b1, 16'h82A5, 1'b0, 7'h00, 8'h00, "spi_write");
    n_vec++;
    if (bus.regs_flat[23:16] !== 8'hA5) begin
      n_err++;
      $display("FAIL spi_write_reg2: got %h expected a5", bus.regs_flat[23:16]);
    end
  endtask

  task automatic test_rejects();
    transact(1'b1, 16'h02FF, 1'b0, 7'h00, 8'h00, "reject_read");
    transact(1'b1, 16'h8511, 1'b0, 7'h00, 8'h00, "reject_addr5");
    transact(1'b0, 16'h0000, 1'b1, 7'h7F, 8'h3C, "reject_loc_7f");
    transact(1'b0, 16'h0000, 1'b1, 7'h04, 8'hC3, "loc_write_max");
  endtask

  task automatic test_contention();
    int spi_c = -1;
    int loc_c = -1;
    do_reset();
    bus.spi_valid = 1'b1;
    bus.spi_frame = 16'h8111;
    bus.loc_valid = 1'b1;
    bus.loc_addr  = 7'h01;
    bus.loc_data  = 8'h22;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.spi_ready && spi_c < 0) spi_c = c;
      if (bus.loc_ready && loc_c < 0) loc_c = c;
      @(negedge clk);
      if (spi_c >= 0) bus.spi_valid = 1'b0;
      if (loc_c >= 0) bus.loc_valid = 1'b0;
    end
    m_regs[1] = 8'h22; m_last_spi = 1'b0; m_addr = 7'h01; m_wdata = 8'h22;
    n_vec++;
    if (spi_c !== 0 || loc_c !== 3) begin
      n_err++;
      $display("FAIL contention_order: spi grant cycle %0d loc grant cycle %0d expected 0 and 3",
               spi_c, loc_c);
    end
    n_vec++;
    if (bus.regs_flat !== m_flat() || bus.regs_flat[15:8] !== 8'h22) begin
      n_err++;
      $display("FAIL contention_bank: regs_flat=%h expected %h", bus.regs_flat, m_flat());
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    transact(1'b0, 16'h0000, 1'b1, 7'h00, 8'h5A, "pre_mid_write");
    bus.loc_valid = 1'b1;
    bus.loc_addr  = 7'h03;
    bus.loc_data  = 8'h7E;
    #1;
    n_vec++;
    if (bus.loc_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_grant: loc_ready=%b expected 1", bus.loc_ready);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) rst_n = 1'b1;
      #1;
      n_vec++;
      if ({bus.reg_we, bus.reject, bus.regs_flat} !== '0) begin
        n_err++;
        $display("FAIL mid_reset c%0d: we=%b rej=%b regs=%h expected all zero",
                 c, bus.reg_we, bus.reject, bus.regs_flat);
      end
      @(negedge clk);
    end
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      bit sv, lv;
      logic [6:0] a;
      logic [15:0] fr;
      sv = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 6));
      fr = {($urandom_range(0, 4) != 0), a, 8'($urandom)};
      transact(sv, fr, lv, 7'($urandom_range(0, 6)), 8'($urandom), $sformatf("rand%0d", i));
    end
  endtask

`ifdef REG_WRITE_ERR_CNT_EN
  task automatic test_err_cnt();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) transact(1'b1, {1'b0, 7'($urandom_range(0, 4)), 8'($urandom)}, 1'b0,
                               7'h00, 8'h00, $sformatf("errcnt%0d", i));
      else            transact(1'b1, {1'b1, 7'($urandom_range(5, 127)), 8'($urandom)}, 1'b0,
                               7'h00, 8'h00, $sformatf("errcnt%0d", i));
    end
    transact(1'b1, 16'h8099, 1'b0, 7'h00, 8'h00, "errcnt_valid");
    n_vec++;
    if (err_cnt !== 8'hFF) begin
      n_err++;
      $display("FAIL err_cnt_saturate: got %h expected ff", err_cnt);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_spi_write();
    test_rejects();
    test_contention();
    test_reset_mid();
    test_random();
`ifdef REG_WRITE_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
